pulse_stretch: RTL and testbench

Turns single-cycle event strobes into human-visible output pulses of fixed length, separated by a guaranteed minimum off time. It is the output-side counterpart of the input conditioning chain (synchronizer, debouncer, edge detector). Typical loads are an LED, a buzzer or a scope test pin. With queuing compiled in, each strobe, including strobes that arrive during a pulse, produces its own distinct pulse, up to a bounded backlog.

---
 rtl/pulse_stretch.sv | 158 +++++++++++++++
 tb/tb_pulse_stretch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// Purpose: stretches single-cycle strobes into ON_CYCLES-long pulses separated by at least GAP_CYCLES low cycles.
// Latency: a strobe sampled at edge k drives out high from cycle k+1; out/busy/pending/dropped are all registered.
// Backpressure: none toward the source; strobes arriving mid-pulse queue (PULSE_STRETCH_QUEUE_EN) or are discarded and flagged on dropped.
module pulse_stretch #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int ON_MS       = 50,
  parameter int GAP_MS      = 50,
  parameter int MAX_PENDING = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in,
  output logic                               out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               dropped
);

  localparam int ON_CYCLES  = (CLK_HZ / 1000) * ON_MS;
  localparam int GAP_RAW    = (CLK_HZ / 1000) * GAP_MS;
  localparam int GAP_CYCLES = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int PEND_W     = $clog2(MAX_PENDING + 1);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               out_nxt;
  logic               busy_nxt;
  logic               drop_nxt;
  logic               gap_exit;
  logic               busy_st;
  logic               pend_nz;
  logic               take_direct;

  // Last GAP cycle: the only point where a new pulse may start back-to-back.
  assign gap_exit    = (state_q == GAP) && (cnt_q == '0);
  assign busy_st     = (state_q != IDLE);
  // With an empty backlog, a strobe on the GAP exit cycle starts the next pulse itself.
  assign take_direct = gap_exit && !pend_nz && in;

`ifdef PULSE_STRETCH_QUEUE_EN
  logic [PEND_W-1:0] pend_q;
  logic              enq;
  logic              deq;

  assign pend_nz  = (pend_q != '0);
  assign deq      = gap_exit && pend_nz;
  // A full backlog still accepts a strobe when an entry leaves in the same cycle.
  assign enq      = in && busy_st && !take_direct && ((pend_q < PEND_W'(MAX_PENDING)) || deq);
  assign drop_nxt = in && busy_st && !take_direct && !enq;

  // Backlog counter: +1 per queued strobe, -1 per replayed pulse, unchanged when both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (enq && !deq) begin
      pend_q <= pend_q + PEND_W'(1);
    end else if (deq && !enq) begin
      pend_q <= pend_q - PEND_W'(1);
    end
  end

  assign pending = pend_q;
`else
  // No backlog: every strobe that cannot start a pulse immediately is discarded.
  assign pend_nz  = 1'b0;
  assign drop_nxt = in && busy_st && !take_direct;
  assign pending  = '0;
`endif

  // State register and shared down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter is reloaded on every state entry and only decremented while nonzero.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in) begin
          state_nxt = ON;
          cnt_nxt   = ON_LOAD;
        end
      end
      ON: begin
        if (cnt_q == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pend_nz || in) begin
            state_nxt = ON;
            cnt_nxt   = ON_LOAD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with the state.
  always_comb begin
    out_nxt  = 1'b0;
    busy_nxt = 1'b0;
    if (state_nxt == ON) begin
      out_nxt = 1'b1;
    end
    if (state_nxt != IDLE) begin
      busy_nxt = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      out     <= out_nxt;
      busy    <= busy_nxt;
      dropped <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with ON_CYCLES = GAP_CYCLES = 4 and MAX_PENDING = 2.
// Cycle c is the clock period after the c-th edge of a scenario; outputs are sampled on the falling edge.
// Expectations follow the build: backlog enabled only when PULSE_STRETCH_QUEUE_EN is defined.
module tb_pulse_stretch;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam bit QON = 1'b1;
`else
  localparam bit QON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       out;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  pulse_stretch #(
    .CLK_HZ(4000),
    .ON_MS(1),
    .GAP_MS(1),
    .MAX_PENDING(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .out(out),
    .busy(busy),
    .pending(pending),
    .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the strobe for one cycle, then sit at that cycle's falling edge.
  task automatic next_cycle(input logic v);
    @(posedge clk);
    #1;
    in = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] got;
    in    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {out, busy, pending, dropped};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state out/busy/pend/drop got %b exp %b", got, 5'b00000);
    end
    // Strobe held across release: the first edge after release must take it.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in = 1'b0;
    @(negedge clk);
    got = {out, busy, pending, dropped};
    checks++;
    if (got !== 5'b11000) begin
      errors++;
      $display("FAIL first_event out/busy/pend/drop got %b exp %b", got, 5'b11000);
    end
  endtask

  task automatic test_single();
    logic [4:0] got;
    logic [4:0] exp;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      next_cycle(c == 10);
      exp = {(c >= 11 && c <= 14), (c >= 11 && c <= 18), 2'b00, 1'b0};
      got = {out, busy, pending, dropped};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single c=%0d out/busy/pend/drop got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_queue_two();
    logic [4:0] got;
    logic [4:0] exp;
    logic [1:0] ep;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      next_cycle(c == 10 || c == 12);
      ep  = (QON && c >= 13 && c <= 18) ? 2'd1 : 2'd0;
      exp = {((c >= 11 && c <= 14) || (QON && c >= 19 && c <= 22)),
             (c >= 11 && c <= (QON ? 26 : 18)),
             ep,
             (!QON && c == 13)};
      got = {out, busy, pending, dropped};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL queue_two c=%0d out/busy/pend/drop got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [4:0] got;
    logic [4:0] exp;
    logic [1:0] ep;
    logic       eo;
    logic       prev;
    int         rises;
    prev  = 1'b0;
    rises = 0;
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      next_cycle(c >= 10 && c <= 13);
      if (QON) begin
        ep = (c == 12) ? 2'd1 : (c >= 13 && c <= 18) ? 2'd2 : (c >= 19 && c <= 26) ? 2'd1 : 2'd0;
        eo = (c >= 11 && c <= 14) || (c >= 19 && c <= 22) || (c >= 27 && c <= 30);
        exp = {eo, (c >= 11 && c <= 34), ep, (c == 14)};
      end else begin
        exp = {(c >= 11 && c <= 14), (c >= 11 && c <= 18), 2'b00, (c >= 12 && c <= 14)};
      end
      got = {out, busy, pending, dropped};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overflow c=%0d out/busy/pend/drop got %b exp %b", c, got, exp);
      end
      if (out && !prev) rises++;
      prev = out;
    end
    checks++;
    if (rises != (QON ? 3 : 1)) begin
      errors++;
      $display("FAIL overflow_pulse_count got %0d exp %0d", rises, (QON ? 3 : 1));
    end
  endtask

  task automatic test_gap_exit();
    logic [4:0] got;
    logic [4:0] exp;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      next_cycle(c == 10 || c == 18);
      exp = {((c >= 11 && c <= 14) || (c >= 19 && c <= 22)), (c >= 11 && c <= 26), 2'b00, 1'b0};
      got = {out, busy, pending, dropped};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gap_exit c=%0d out/busy/pend/drop got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    logic [4:0] exp;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      next_cycle(c == 10 || c == 11);
      exp = {(c >= 11), (c >= 11), ((QON && c == 12) ? 2'd1 : 2'd0), (!QON && c == 12)};
      got = {out, busy, pending, dropped};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d out/busy/pend/drop got %b exp %b", c, got, exp);
      end
    end
    // Mid-cycle assertion: outputs must clear without waiting for an edge.
    rst_n = 1'b0;
    #1;
    got = {out, busy, pending, dropped};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset_mid_async out/busy/pend/drop got %b exp %b", got, 5'b00000);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle(1'b0);
      got = {out, busy, pending, dropped};
      checks++;
      if (got !== 5'b00000) begin
        errors++;
        $display("FAIL reset_mid_no_replay c=%0d out/busy/pend/drop got %b exp %b", c, got, 5'b00000);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;
    test_reset();
    test_single();
    test_queue_two();
    test_overflow();
    test_gap_exit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
